// File: rtl/mem_req_ctrl_if.sv
// Request/response/memory-pin bundle for mem_req_ctrl.
// The controller takes the slave view; the requester plus the memory take the master view.
interface mem_req_ctrl_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_addr, mem_wr, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_addr, mem_wr, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Sequences one read/write request at a time onto a single-port synchronous memory.
// Optional statistics counters (wr_count/rd_count) are built when MEM_REQ_CTRL_STATS_EN is defined.
module mem_req_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_req_ctrl_if.slave        bus
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RSP   = 2'd3
    } state_t;

    state_t                state_q;
    logic                  mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;

    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
        $error("mem_req_ctrl: widths must be positive");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        mem_addr_q <= bus.req_addr;
                        mem_din_q  <= bus.req_wdata;
                        mem_wr_q   <= bus.req_wr;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // mem_wr_q still records the request type for this one cycle
                    mem_wr_q <= 1'b0;
                    state_q  <= mem_wr_q ? IDLE : CAPT;
                end
                CAPT: begin
                    rsp_rdata_q <= bus.mem_dout;
                    rsp_addr_q  <= mem_addr_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;

`ifdef MEM_REQ_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic                 wr_inc, rd_inc;

    assign wr_inc = (state_q == ISSUE) && mem_wr_q;
    assign rd_inc = (state_q == RSP) && bus.rsp_ready;

    // Saturating increments: hold at all-ones
    always_comb begin
        wr_count_d = wr_count_q;
        rd_count_d = rd_count_q;
        if (wr_inc && (wr_count_q != '1)) wr_count_d = wr_count_q + CNT_WIDTH'(1);
        if (rd_inc && (rd_count_q != '1)) rd_count_d = rd_count_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural single-port synchronous memory.
// Counter checks are built when MEM_REQ_CTRL_STATS_EN is defined.
module tb_mem_req_ctrl;
    localparam int DW = 2;
    localparam int AW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_REQ_CTRL_STATS_EN
    logic [CW-1:0] wr_count, rd_count;
`endif

    mem_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_REQ_CTRL_STATS_EN
        ,
        .wr_count (wr_count),
        .rd_count (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // Read-first synchronous memory: dout registers the addressed word every edge
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        check("wr_req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("wr_mem_wr_high", bus.mem_wr, 1);
        check("wr_mem_addr", bus.mem_addr, a);
        check("wr_mem_din", bus.mem_din, d);
        check("wr_req_ready_busy", bus.req_ready, 0);
        @(negedge clk);
        check("wr_mem_wr_low", bus.mem_wr, 0);
        check("wr_req_ready_back", bus.req_ready, 1);
        $display("WRITE addr=%0d data=%0d", a, d);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int stall);
        @(negedge clk);
        bus.rsp_ready = (stall == 0);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = a;
        bus.req_wdata = 2'd0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rd_issue_mem_wr", bus.mem_wr, 0);
        check("rd_issue_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        check("rd_capt_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        check("rd_rsp_valid", bus.rsp_valid, 1);
        check("rd_rsp_rdata", bus.rsp_rdata, exp);
        check("rd_rsp_addr", bus.rsp_addr, a);
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'b1;
            bus.req_addr  = ~a;
            bus.req_wdata = 2'd1;
            @(negedge clk);
            check("stall_rsp_valid", bus.rsp_valid, 1);
            check("stall_rsp_rdata", bus.rsp_rdata, exp);
            check("stall_rsp_addr", bus.rsp_addr, a);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_mem_wr", bus.mem_wr, 0);
            check("stall_mem_addr", bus.mem_addr, a);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rd_rsp_done", bus.rsp_valid, 0);
        check("rd_req_ready_back", bus.req_ready, 1);
        check("rd_no_stray_write", bus.mem_wr, 0);
        $display("READ  addr=%0d data=%0d stall=%0d", a, bus.rsp_rdata, stall);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_mem_wr", bus.mem_wr, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
`ifdef MEM_REQ_CTRL_STATS_EN
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
`endif
        rst_n = 1'b1;
        $display("RESET released");

        // Single write then read back
        do_write(2'd2, 2'd3);
        do_read(2'd2, 2'd3, 0);

        // Fill all addresses, read back in reverse
        for (int i = 0; i < 4; i++) do_write(AW'(i), DW'(i));
        for (int i = 3; i >= 0; i--) do_read(AW'(i), DW'(i), 0);

        // Response back-pressure for 5 cycles with a competing request
        do_read(2'd3, 2'd3, 5);

        // Reset during ISSUE of a write aborts it
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 2'd1;
        bus.req_wdata = 2'd2;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_mem_wr_before", bus.mem_wr, 1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_wr_after", bus.mem_wr, 0);
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_mem_addr", bus.mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("ABORT write addr=1 data=2");
        do_read(2'd1, 2'd1, 0);

`ifdef MEM_REQ_CTRL_STATS_EN
        // Counter saturation at CNT_WIDTH=2
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("stats_rst_wr", wr_count, 0);
        check("stats_rst_rd", rd_count, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_write(AW'(i), DW'(i + 1));
            check("stats_wr_step", wr_count, (i + 1 > 3) ? 3 : i + 1);
        end
        do_read(2'd0, 2'd1, 0);
        do_read(2'd2, 2'd3, 0);
        check("stats_wr_count", wr_count, 3);
        check("stats_rd_count", rd_count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
